// File: rtl/arb_pkg.sv
// Shared types and constants for the arbiter requester front-end.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  localparam int              PRIO_W    = 2;
  localparam logic [PRIO_W-1:0] PRIO_MAX = 2'd3;
  localparam int              DEF_LEN_W = 4;
  localparam int              DEF_DEPTH = 4;

  // Saturating priority bump; never wraps past PRIO_MAX.
  function automatic logic [PRIO_W-1:0] prio_inc(input logic [PRIO_W-1:0] p);
    return (p == PRIO_MAX) ? PRIO_MAX : p + 2'd1;
  endfunction
endpackage

// File: rtl/arb_req_fifo.sv
// DEPTH x W synchronous job FIFO with occupancy count; pushes while full are ignored.
module arb_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == CW'(0));
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/arb_requester.sv
// Client front-end for the two-way arbiter: queues jobs, requests for each job's
// beat count, and ages its priority while left waiting for a grant.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int AGE_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  input  logic [LEN_W-1:0]           job_len,
  input  logic [PRIO_W-1:0]          base_prio,
  input  logic                       gnt,
  output logic                       req,
  output logic [PRIO_W-1:0]          prio,
  output logic                       beat,
  output logic                       done,
  output logic                       job_drop,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] pending
);
  localparam int WAIT_W    = (AGE_CYCLES > 2) ? $clog2(AGE_CYCLES) : 1;
  localparam int AGE_LAST_I = (AGE_CYCLES > 0) ? AGE_CYCLES - 1 : 0;
  localparam logic [WAIT_W-1:0] AGE_LAST = WAIT_W'(AGE_LAST_I);
  localparam logic [LEN_W:0]    REM_ONE  = {{LEN_W{1'b0}}, 1'b1};

  state_t              r_state;
  logic                r_req;
  logic [PRIO_W-1:0]   r_prio;
  logic                r_done;
  logic                r_drop;
  logic [LEN_W:0]      r_rem;
  logic [WAIT_W-1:0]   r_wait;
  logic [LEN_W-1:0]    w_head;
  logic                w_empty;
  logic                w_pop;
  logic [LEN_W:0]      w_len_p1;

  assign w_pop    = (r_state == IDLE) && !w_empty;
  assign w_len_p1 = {1'b0, w_head} + REM_ONE;

  arb_req_fifo #(.DEPTH(DEPTH), .W(LEN_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (job_valid),
    .i_din   (job_len),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (full),
    .o_empty (w_empty),
    .o_count (pending)
  );

  assign req      = r_req;
  assign prio     = r_prio;
  assign done     = r_done;
  assign job_drop = r_drop;
  assign beat     = r_req & gnt;

  // IDLE always spends one req-low cycle before popping, giving the arbiter a gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_prio  <= '0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
      r_rem   <= '0;
      r_wait  <= '0;
    end else begin
      r_done <= 1'b0;
      r_drop <= job_valid & full;
      case (r_state)
        IDLE: begin
          r_req  <= 1'b0;
          r_prio <= base_prio;
          r_wait <= '0;
          if (!w_empty) begin
            r_rem   <= w_len_p1;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ, XFER: begin
          if (gnt) begin
            r_rem  <= r_rem - REM_ONE;
            r_prio <= base_prio;
            r_wait <= '0;
            if (r_rem == REM_ONE) begin
              r_req   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_state <= XFER;
            end
          end else if (AGE_CYCLES > 0) begin
            // Starvation guard: bump priority every AGE_CYCLES ungranted cycles.
            if (r_wait == AGE_LAST) begin
              r_prio <= prio_inc(r_prio);
              r_wait <= '0;
            end else begin
              r_wait <= r_wait + WAIT_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end
endmodule
